// File: rtl/line_pkg.sv
// rtl/line_pkg.sv - shared encodings for the line tracker and the motor block
//   Mode encodings (MODE_*), FSM state encodings (ST_*), steering memory (DIR_*)
//   and a helper mapping a remembered direction to its veer mode.
package line_pkg;

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_FWD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FOLLOW = 2'b01,
    ST_SEARCH = 2'b10,
    ST_LOST   = 2'b11
  } state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  // Veer mode used while hunting for the line in the last known direction.
  function automatic logic [1:0] dir_mode(input dir_t d);
    return (d == DIR_RIGHT) ? MODE_RIGHT : MODE_LEFT;
  endfunction

endpackage

// File: rtl/sensor_filter.sv
// rtl/sensor_filter.sv - two-flop synchroniser plus debounce for one sensor bit
//   clk  : system clock
//   rst  : synchronous reset, active-low
//   din  : raw asynchronous sensor bit
//   dout : debounced bit, changes only after DEB_CYCLES consecutive differing cycles
module sensor_filter #(
  parameter int DEB_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      // Accept the new level on the DEB_CYCLES-th consecutive differing cycle.
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/line_tracker.sv
// rtl/line_tracker.sv - follow/search/lost decision stage feeding the motor controller
//   clk    : 100 MHz system clock
//   rst    : synchronous reset, active-low
//   en     : run enable, 0 forces IDLE
//   sensor : raw {left, centre, right} line sensors, 1 = line
//   mode   : registered drive mode (00 stop, 01 veer right, 10 veer left, 11 forward)
//   state  : registered FSM state for debug LEDs
//   lost   : registered, high while in LOST
module line_tracker
  import line_pkg::*;
#(
  parameter int DEB_CYCLES    = 100_000,
  parameter int SEARCH_CYCLES = 200_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] sensor,
  output logic [1:0] mode,
  output logic [1:0] state,
  output logic       lost
);

  localparam int SCW = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;

  logic [2:0] filt;

  for (genvar i = 0; i < 3; i++) begin : g_filt
    sensor_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt (
      .clk  (clk),
      .rst  (rst),
      .din  (sensor[i]),
      .dout (filt[i])
    );
  end

  state_t         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic           lost_q, lost_d;
  dir_t           last_dir_q, last_dir_d;
  logic [SCW-1:0] scnt_q, scnt_d;

  // Steering decode for a non-empty sensor pattern; shared by FOLLOW and reacquire.
  logic [1:0] fol_mode;
  dir_t       fol_dir;

  always_comb begin
    fol_mode = MODE_FWD;
    fol_dir  = last_dir_q;
    case (filt)
      3'b110, 3'b100: begin
        fol_mode = MODE_LEFT;
        fol_dir  = DIR_LEFT;
      end
      3'b011, 3'b001: begin
        fol_mode = MODE_RIGHT;
        fol_dir  = DIR_RIGHT;
      end
      default: fol_mode = MODE_FWD;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lost_d     = 1'b0;
    last_dir_d = last_dir_q;
    scnt_d     = '0;
    if (!en) begin
      state_d = ST_IDLE;
      mode_d  = MODE_STOP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mode_d  = MODE_STOP;
          state_d = ST_FOLLOW;
        end
        ST_FOLLOW: begin
          if (filt == 3'b000) begin
            state_d = ST_SEARCH;
            mode_d  = dir_mode(last_dir_q);
          end else begin
            mode_d     = fol_mode;
            last_dir_d = fol_dir;
          end
        end
        ST_SEARCH: begin
          // Reacquire is checked first so it wins over a coincident timeout.
          if (filt != 3'b000) begin
            state_d    = ST_FOLLOW;
            mode_d     = fol_mode;
            last_dir_d = fol_dir;
          end else if (scnt_q == SCW'(SEARCH_CYCLES - 1)) begin
            state_d = ST_LOST;
            mode_d  = MODE_STOP;
            lost_d  = 1'b1;
          end else begin
            mode_d = dir_mode(last_dir_q);
            scnt_d = scnt_q + SCW'(1);
          end
        end
        ST_LOST: begin
          mode_d = MODE_STOP;
          lost_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          mode_d  = MODE_STOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_STOP;
      lost_q     <= 1'b0;
      last_dir_q <= DIR_LEFT;
      scnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      lost_q     <= lost_d;
      last_dir_q <= last_dir_d;
      scnt_q     <= scnt_d;
    end
  end

  assign mode  = mode_q;
  assign state = state_q;
  assign lost  = lost_q;

endmodule

// File: tb/tb_line_tracker.sv
// tb/tb_line_tracker.sv - directed self-checking bench for line_tracker
module tb_line_tracker;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] sensor;
  logic [1:0] mode;
  logic [1:0] state;
  logic       lost;

  int tests;
  int fails;

  line_tracker #(.DEB_CYCLES(4), .SEARCH_CYCLES(50)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sensor (sensor),
    .mode   (mode),
    .state  (state),
    .lost   (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Observed vector is {state, mode, lost}.
  task automatic test_reset();
    rst = 1'b0; en = 1'b1; sensor = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      tests++;
      if ({state, mode, lost} !== 5'b00_00_0) begin
        fails++; $display("FAIL reset_hold[%0d]: got %b want %b", i, {state, mode, lost}, 5'b00_00_0);
      end
    end
    rst = 1'b1;
    tick(1);
    tests++;
    if ({state, mode, lost} !== 5'b01_00_0) begin
      fails++; $display("FAIL reset_edge1: got %b want %b", {state, mode, lost}, 5'b01_00_0);
    end
    // filt is still 000 on edge 2, so FOLLOW drops into SEARCH veering LEFT.
    tick(5);
    tests++;
    if ({state, mode, lost} !== 5'b10_10_0) begin
      fails++; $display("FAIL reset_edge6: got %b want %b", {state, mode, lost}, 5'b10_10_0);
    end
    tick(1);
    tests++;
    if ({state, mode, lost} !== 5'b01_11_0) begin
      fails++; $display("FAIL reset_edge7: got %b want %b", {state, mode, lost}, 5'b01_11_0);
    end
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    sensor = 3'b000;
    tick(3);
    sensor = 3'b010;
    for (int i = 0; i < 12; i++) begin
      if ({state, mode} !== 4'b01_11) bad++;
      tick(1);
    end
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL glitch3_reject: got %0d bad cycles want 0", bad);
    end
    sensor = 3'b000;
    tick(4);
    sensor = 3'b010;
    tick(2);
    tests++;
    if ({state, mode} !== 4'b01_11) begin
      fails++; $display("FAIL glitch4_e6: got %b want %b", {state, mode}, 4'b01_11);
    end
    tick(1);
    tests++;
    if ({state, mode, lost} !== 5'b10_10_0) begin
      fails++; $display("FAIL glitch4_search: got %b want %b", {state, mode, lost}, 5'b10_10_0);
    end
    tick(10);
    tests++;
    if ({state, mode} !== 4'b01_11) begin
      fails++; $display("FAIL glitch4_recover: got %b want %b", {state, mode}, 4'b01_11);
    end
  endtask

  task automatic test_veer_search();
    sensor = 3'b011;
    tick(10);
    tests++;
    if ({state, mode} !== 4'b01_01) begin
      fails++; $display("FAIL veer_right: got %b want %b", {state, mode}, 4'b01_01);
    end
    sensor = 3'b000;
    tick(7);
    tests++;
    if ({state, mode} !== 4'b10_01) begin
      fails++; $display("FAIL search_right_enter: got %b want %b", {state, mode}, 4'b10_01);
    end
    tick(20);
    tests++;
    if ({state, mode, lost} !== 5'b10_01_0) begin
      fails++; $display("FAIL search_right_hold: got %b want %b", {state, mode, lost}, 5'b10_01_0);
    end
    sensor = 3'b010;
    tick(10);
    tests++;
    if ({state, mode} !== 4'b01_11) begin
      fails++; $display("FAIL search_reacquire: got %b want %b", {state, mode}, 4'b01_11);
    end
  endtask

  task automatic test_lost();
    sensor = 3'b000;
    tick(56);
    tests++;
    if ({state, mode, lost} !== 5'b10_01_0) begin
      fails++; $display("FAIL lost_pre: got %b want %b", {state, mode, lost}, 5'b10_01_0);
    end
    tick(1);
    tests++;
    if ({state, mode, lost} !== 5'b11_00_1) begin
      fails++; $display("FAIL lost_enter: got %b want %b", {state, mode, lost}, 5'b11_00_1);
    end
    sensor = 3'b010;
    tick(10);
    tests++;
    if ({state, mode, lost} !== 5'b11_00_1) begin
      fails++; $display("FAIL lost_sticky: got %b want %b", {state, mode, lost}, 5'b11_00_1);
    end
    en = 1'b0;
    tick(1);
    tests++;
    if ({state, mode, lost} !== 5'b00_00_0) begin
      fails++; $display("FAIL lost_exit: got %b want %b", {state, mode, lost}, 5'b00_00_0);
    end
    en = 1'b1;
    tick(2);
    tests++;
    if ({state, mode, lost} !== 5'b01_11_0) begin
      fails++; $display("FAIL lost_rearm: got %b want %b", {state, mode, lost}, 5'b01_11_0);
    end
  endtask

  task automatic test_reacquire_timeout();
    sensor = 3'b000;
    tick(50);
    sensor = 3'b010;
    tick(6);
    tests++;
    if (state !== 2'b10) begin
      fails++; $display("FAIL reacq_pre: got %b want %b", state, 2'b10);
    end
    tick(1);
    tests++;
    if ({state, mode, lost} !== 5'b01_11_0) begin
      fails++; $display("FAIL reacq_priority: got %b want %b", {state, mode, lost}, 5'b01_11_0);
    end
  endtask

  task automatic test_en_mid_search();
    sensor = 3'b000;
    tick(17);
    tests++;
    if (state !== 2'b10) begin
      fails++; $display("FAIL en_search_state: got %b want %b", state, 2'b10);
    end
    en = 1'b0;
    tick(1);
    tests++;
    if ({state, mode, lost} !== 5'b00_00_0) begin
      fails++; $display("FAIL en_drop: got %b want %b", {state, mode, lost}, 5'b00_00_0);
    end
    sensor = 3'b100;
    tick(10);
    tests++;
    if ({state, mode} !== 4'b00_00) begin
      fails++; $display("FAIL en_idle_hold: got %b want %b", {state, mode}, 4'b00_00);
    end
    en = 1'b1;
    tick(1);
    tests++;
    if (state !== 2'b01) begin
      fails++; $display("FAIL en_refollow: got %b want %b", state, 2'b01);
    end
    tick(1);
    tests++;
    if ({state, mode} !== 4'b01_10) begin
      fails++; $display("FAIL en_veer_left: got %b want %b", {state, mode}, 4'b01_10);
    end
    sensor = 3'b000;
    tick(7);
    tests++;
    if ({state, mode} !== 4'b10_10) begin
      fails++; $display("FAIL en_search_left: got %b want %b", {state, mode}, 4'b10_10);
    end
    tick(49);
    tests++;
    if (state !== 2'b10) begin
      fails++; $display("FAIL en_cnt_restart_pre: got %b want %b", state, 2'b10);
    end
    tick(1);
    tests++;
    if ({state, mode, lost} !== 5'b11_00_1) begin
      fails++; $display("FAIL en_cnt_restart_lost: got %b want %b", {state, mode, lost}, 5'b11_00_1);
    end
  endtask

  task automatic test_reset_mid_search();
    en = 1'b1;
    rst = 1'b0;
    sensor = 3'b010;
    tick(1);
    tests++;
    if ({state, mode, lost} !== 5'b00_00_0) begin
      fails++; $display("FAIL reset_from_lost: got %b want %b", {state, mode, lost}, 5'b00_00_0);
    end
    rst = 1'b1;
    tick(7);
    tests++;
    if ({state, mode, lost} !== 5'b01_11_0) begin
      fails++; $display("FAIL reset_rerun: got %b want %b", {state, mode, lost}, 5'b01_11_0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0; en = 1'b0; sensor = 3'b000;
    test_reset();
    test_glitch();
    test_veer_search();
    test_lost();
    test_reacquire_timeout();
    test_en_mid_search();
    test_reset_mid_search();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/line_tracker.md
Name: line_tracker

Overview:
Upstream decision stage for the two-motor drive block. It takes three reflective line sensors, synchronises and debounces them, and runs a follow/search/lost state machine. It emits the 2-bit drive mode consumed by the motor controller. It runs on the 100 MHz system clock.

Parameters:
DEB_CYCLES, 100_000, consecutive cycles a synchronised sensor value must differ from the filtered value before the filtered value is updated (1 ms).
SEARCH_CYCLES, 200_000_000, maximum cycles spent searching after the line is lost before stopping (2 s).

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  reset, synchronous, active-low (0 = reset)
en  input  1  run enable from the top level; 0 forces the IDLE state
sensor  input  3  raw sensors {left, centre, right}, asynchronous; 1 = line detected
mode  output  2  drive mode: 00 stop, 01 veer right, 10 veer left, 11 forward
state  output  2  current FSM state, for debug LEDs
lost  output  1  high while in the LOST state

Behaviour:
- Reset: applied at a clk edge while rst=0. Results:
  - mode=00, lost=0, state=IDLE.
  - Synchroniser flops, filtered sensors and all counters are 0.
  - last_dir=LEFT.
  - Reset mid-search or mid-debounce discards all progress.
- Synchroniser: two flops per sensor bit. s_sync lags sensor by 2 edges.
- Filter, per bit:
  - If s_sync equals filt, the counter clears.
  - Otherwise the counter increments. On the edge where the counter equals DEB_CYCLES-1 and the bit still differs, filt takes s_sync and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never reaches filt.
- mode, state and lost are registered.
- Latency from a clean sensor step to mode: 2 + DEB_CYCLES + 1 edges.
- States: IDLE=00, FOLLOW=01, SEARCH=10, LOST=11.
- en=0 in any state: the next state is IDLE. en has priority over every other transition.
- IDLE:
  - mode=00.
  - When en=1, go to FOLLOW.
  - Clear the search counter.
- FOLLOW, decoded on filt {L,C,R}:
  - 010, 111, 101 -> mode=11.
  - 110, 100 -> mode=10, last_dir<=LEFT.
  - 011, 001 -> mode=01, last_dir<=RIGHT.
  - 000 -> go to SEARCH. mode takes the last_dir mode on the same edge. Search counter <=0.
- SEARCH:
  - mode is held at the last_dir mode (10 for LEFT, 01 for RIGHT). The search counter increments each cycle.
  - If filt is nonzero, go to FOLLOW. mode is decoded from filt on that same edge and the counter clears.
  - Else, if the counter equals SEARCH_CYCLES-1, go to LOST.
  - If both conditions hold on the same cycle, reacquire (FOLLOW) takes priority over timeout.
- LOST:
  - mode=00, lost=1.
  - Sensors are ignored. Only en=0 (to IDLE) or reset exits.
  - lost drops on the same edge that leaves LOST.
- Widths:
  - Debounce counters are $clog2(DEB_CYCLES) bits. The search counter is $clog2(SEARCH_CYCLES) bits.
  - Counters never wrap: they clear on each transition.
- Re-entry to FOLLOW from IDLE uses current filt with no extra debounce. last_dir persists across IDLE and is cleared only by reset.

Decomposition:
- Shared package line_pkg holds:
  - mode encodings MODE_STOP/MODE_RIGHT/MODE_LEFT/MODE_FWD (00/01/10/11);
  - state encodings ST_IDLE/ST_FOLLOW/ST_SEARCH/ST_LOST;
  - DIR_LEFT/DIR_RIGHT.
- The motor block imports the same mode constants.
- One sub-module, sensor_filter (parameter DEB_CYCLES; ports clk, rst, din, dout), contains the 2-flop synchroniser and debounce. It is instantiated three times.

Test Plan:
All scenarios use DEB_CYCLES=4 and SEARCH_CYCLES=50.
1. Reset held low for 3 cycles with en=1 and sensor=010 -> mode=00, state=00, lost=0 during reset. After release: state=01 on edge 1, and mode=11 by edge 2+4+1=7 after sensor is stable.
2. FOLLOW with sensor=010, then a 3-cycle pulse to 000 -> mode stays 11 throughout (glitch rejected). A 4-cycle pulse -> SEARCH entered and mode=10 (last_dir LEFT from reset).
3. sensor 010->011 then ->000 -> mode 11 -> 01 -> 01 held in SEARCH, state=10. Sensor returns to 010 after 20 cycles -> state=01, mode=11.
4. sensor=000 held from FOLLOW -> after 50 SEARCH cycles state=11, mode=00, lost=1. Sensor later returns to 010 -> still LOST. en=0 -> IDLE next edge, lost=0.
5. Reacquire on the timeout cycle: filt becomes nonzero on exactly the 50th SEARCH cycle -> FOLLOW, not LOST.
6. en dropped mid-SEARCH at cycle 10 -> IDLE, mode=00. en=1 with sensor=100 -> FOLLOW, mode=10; search counter restarts from 0 on the next loss.
